// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM five-stage pipeline control blocks.
package arm_pipe_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush generation for the five-stage pipeline: RAW stalls, taken-branch
// squash and SRAM wait-state holds, with a per-request wait watchdog.
module pipeline_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_en,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 hasSrc1,
  input  logic                 hasSrc2,
  input  logic [REG_IDX_W-1:0] EXE_Dest,
  input  logic                 EXE_WB_EN,
  input  logic                 EXE_MEM_R_EN,
  input  logic [REG_IDX_W-1:0] MEM_Dest,
  input  logic                 MEM_WB_EN,
  input  logic                 B_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 id_ex_freeze,
  output logic                 back_freeze,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic match1_exe, match2_exe, match1_mem, match2_mem;
  logic raw, mem_stall, branch_flush, hazard, run;

  // Source/destination compare; R15 is treated like any other register.
  always_comb begin
    match1_exe = hasSrc1 & (src1 == EXE_Dest) & EXE_WB_EN;
    match2_exe = hasSrc2 & (src2 == EXE_Dest) & EXE_WB_EN;
    match1_mem = hasSrc1 & (src1 == MEM_Dest) & MEM_WB_EN;
    match2_mem = hasSrc2 & (src2 == MEM_Dest) & MEM_WB_EN;
    if (fwd_en) begin
      raw = (match1_exe | match2_exe) & EXE_MEM_R_EN;
    end else begin
      raw = match1_exe | match2_exe | match1_mem | match2_mem;
    end
  end

  // Memory wait tracking; the stall is released once MAX_WAIT cycles are spent.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    mem_stall     = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = mem_req & ~mem_ready;
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      WAIT: begin
        mem_stall = mem_req & ~mem_ready & (wait_cnt_q < WAIT_LIMIT);
        if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          if (mem_req & ~mem_ready) begin
            mem_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // A taken branch overrides the RAW stall: the ID instruction is wrong-path.
  assign run          = ~rst;
  assign branch_flush = B_taken & ~mem_stall;
  assign hazard       = raw & ~B_taken & ~mem_stall;

  assign pc_freeze    = run & (mem_stall | hazard);
  assign if_id_freeze = run & (mem_stall | hazard);
  assign if_id_flush  = run & branch_flush;
  assign id_ex_flush  = run & (branch_flush | hazard);
  assign id_ex_freeze = run & mem_stall;
  assign back_freeze  = run & mem_stall;
  assign mem_timeout  = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_freeze),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (if_id_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed checks of pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MAXW = 15;
  localparam int unsigned CW   = 5;
  localparam int          MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fwd_en, hasSrc1, hasSrc2, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic          B_taken, mem_req, mem_ready;
  logic [3:0]    src1, src2, EXE_Dest, MEM_Dest;
  logic          pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, id_ex_freeze, back_freeze;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .src1(src1), .src2(src2),
    .hasSrc1(hasSrc1), .hasSrc2(hasSrc2), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .B_taken(B_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .id_ex_freeze(id_ex_freeze), .back_freeze(back_freeze),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: stall cycles spent on the current request, sticky error, counters.
  int   waited = 0;
  int   sc = 0;
  int   fc = 0;
  bit   to = 1'b0;
  logic [5:0] obs_ctrl;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Does the ID instruction need a value that cannot yet be delivered?
  function automatic bit raw_exp();
    bit r = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bit         used = (s == 0) ? hasSrc1 : hasSrc2;
      logic [3:0] idx  = (s == 0) ? src1 : src2;
      if (used) begin
        if (EXE_WB_EN && idx == EXE_Dest && (!fwd_en || EXE_MEM_R_EN)) r = 1'b1;
        if (!fwd_en && MEM_WB_EN && idx == MEM_Dest) r = 1'b1;
      end
    end
    return r;
  endfunction

  // Check one cycle against the model, advance the model past the coming edge.
  task automatic tick();
    bit         stall, bflush, haz, frz;
    logic [5:0] exp;
    #1;
    stall  = mem_req && !mem_ready && (waited < int'(MAXW));
    bflush = B_taken && !stall;
    haz    = raw_exp() && !B_taken && !stall;
    frz    = stall || haz;
    exp    = rst ? 6'b0 : {frz, frz, bflush, bflush || haz, stall, stall};
    obs_ctrl = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, id_ex_freeze, back_freeze};
    chk_eq("ctrl", 32'(obs_ctrl), 32'(exp));
    chk_eq("stall_cycles", 32'(stall_cycles), sc);
    chk_eq("flush_events", 32'(flush_events), fc);
    chk_eq("mem_timeout", 32'(mem_timeout), 32'(to));
    if (rst) begin
      waited = 0; to = 1'b0; sc = 0; fc = 0;
    end else begin
      if (frz && sc < MAXC) sc++;
      if (bflush && fc < MAXC) fc++;
      if (stall) begin
        waited++;
      end else begin
        if (mem_req && !mem_ready && waited > 0) to = 1'b1;
        waited = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    fwd_en = 0; hasSrc1 = 0; hasSrc2 = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0; MEM_WB_EN = 0;
    B_taken = 0; mem_req = 0; mem_ready = 0;
    src1 = 0; src2 = 0; EXE_Dest = 0; MEM_Dest = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  int nbf;
  bit flush_seen;

  initial begin
    set_idle();
    rst = 1; mem_req = 1; B_taken = 1;
    @(negedge clk);
    tick(); tick();
    chk_eq("rst_ctrl", 32'(obs_ctrl), 0);
    rst = 0; set_idle();

    // RAW without forwarding, against EXE then MEM, then unused source
    src1 = 3; hasSrc1 = 1; EXE_Dest = 3; EXE_WB_EN = 1;
    tick(); chk_eq("raw_exe", 32'(obs_ctrl), 32'(6'b110100));
    EXE_WB_EN = 0; MEM_Dest = 3; MEM_WB_EN = 1;
    tick(); chk_eq("raw_mem", 32'(obs_ctrl), 32'(6'b110100));
    hasSrc1 = 0;
    tick(); chk_eq("no_src", 32'(obs_ctrl), 0);

    // Forwarding: only load-use stalls
    do_reset(); set_idle();
    fwd_en = 1; src2 = 5; hasSrc2 = 1; EXE_Dest = 5; EXE_WB_EN = 1;
    tick(); chk_eq("fwd_no_stall", 32'(obs_ctrl), 0);
    EXE_MEM_R_EN = 1;
    tick(); chk_eq("load_use", 32'(obs_ctrl), 32'(6'b110100));
    EXE_MEM_R_EN = 0;
    tick(); chk_eq("ld_use_cnt", 32'(stall_cycles), 1);

    // Branch beats RAW
    EXE_MEM_R_EN = 1; B_taken = 1;
    tick(); chk_eq("br_raw", 32'(obs_ctrl), 32'(6'b001100));
    B_taken = 0; EXE_MEM_R_EN = 0;
    tick(); chk_eq("br_cnt", 32'(flush_events), 1);

    // Branch deferred behind a 4-cycle memory wait
    set_idle(); mem_req = 1; B_taken = 1; nbf = 0; flush_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); nbf += int'(obs_ctrl[0]); flush_seen |= obs_ctrl[3] | obs_ctrl[2];
    end
    mem_ready = 1;
    tick();
    chk_eq("wait_len", nbf, 4);
    chk_eq("wait_noflush", 32'(flush_seen), 0);
    chk_eq("defer_flush", 32'(obs_ctrl[3]), 1);
    set_idle();
    tick(); chk_eq("no_timeout", 32'(mem_timeout), 0);

    // Watchdog: ready never arrives
    do_reset(); set_idle(); mem_req = 1; nbf = 0;
    for (int i = 0; i < 16; i++) begin
      tick(); nbf += int'(obs_ctrl[0]);
    end
    chk_eq("to_len", nbf, 15);
    chk_eq("to_release", 32'(obs_ctrl[0]), 0);
    mem_req = 0;
    tick(); chk_eq("to_set", 32'(mem_timeout), 1);
    for (int i = 0; i < 5; i++) tick();
    chk_eq("to_sticky", 32'(mem_timeout), 1);
    do_reset();
    tick(); chk_eq("to_clear", 32'(mem_timeout), 0);

    // Counter saturation
    do_reset(); set_idle(); B_taken = 1;
    for (int i = 0; i < 40; i++) tick();
    chk_eq("flush_sat", 32'(flush_events), 32'(MAXC));
    set_idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      fwd_en       = 1'($urandom_range(0, 1));
      src1         = 4'($urandom_range(0, 3));
      src2         = 4'($urandom_range(0, 3));
      hasSrc1      = 1'($urandom_range(0, 1));
      hasSrc2      = 1'($urandom_range(0, 1));
      EXE_Dest     = 4'($urandom_range(0, 3));
      MEM_Dest     = 4'($urandom_range(0, 3));
      EXE_WB_EN    = 1'($urandom_range(0, 1));
      EXE_MEM_R_EN = 1'($urandom_range(0, 1));
      MEM_WB_EN    = 1'($urandom_range(0, 1));
      B_taken      = ($urandom_range(0, 5) == 0);
      mem_req      = ($urandom_range(0, 7) != 0);
      mem_ready    = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Generates the freeze and flush controls for the five-stage ARM pipeline's stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It inputs the source-register fields decoded in ID, the destination, write-back and memory-read flags at the outputs of the ID/EX and EX/MEM registers, the EXE-stage branch-taken flag and the SRAM handshake. It stalls on RAW hazards, squashes wrong-path instructions on taken branches and holds the whole pipeline during SRAM wait states. A watchdog bounds each memory wait, and saturating counters record stall and flush activity.

## Interface
- MAX_WAIT, 15: maximum consecutive memory-stall cycles per request (≥1)
- CNT_W, 16: width of the statistics counters
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- fwd_en  in  1  forwarding unit enabled
- src1, src2  in  4 each  ID-stage source registers
- hasSrc1, hasSrc2  in  1 each  source is actually read
- EXE_Dest  in  4  destination at ID/EX output
- EXE_WB_EN, EXE_MEM_R_EN  in  1 each  write-back / load flags at ID/EX output
- MEM_Dest  in  4  destination at EX/MEM output
- MEM_WB_EN  in  1  write-back flag at EX/MEM output
- B_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM stage has an SRAM access
- mem_ready  in  1  SRAM access completes this cycle
- pc_freeze, if_id_freeze  out  1 each  hold PC / IF/ID register
- if_id_flush, id_ex_flush  out  1 each  load bubble into IF/ID / ID/EX
- id_ex_freeze, back_freeze  out  1 each  hold ID/EX / EX/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_cycles, flush_events  out  CNT_W each  saturating statistics

## Operation
- match1 = hasSrc1 & src1==X_Dest & X_WB_EN. X is EXE or MEM. match2 is the same using src2/hasSrc2. R15 is not excluded.
- raw when fwd_en=0: any match against EXE or MEM.
- raw when fwd_en=1: (match1|match2) against EXE only, and only if EXE_MEM_R_EN=1 (load-use).
- FSM states: IDLE, WAIT. wait_cnt is ceil(log2(MAX_WAIT+1)) bits.
- mem_stall, IDLE: mem_req & !mem_ready.
- mem_stall, WAIT: mem_req & !mem_ready & wait_cnt<MAX_WAIT.
- IDLE→WAIT when mem_stall. wait_cnt←1.
- WAIT, mem_stall: stay, wait_cnt+1.
- WAIT, mem_ready or !mem_req: →IDLE. A dropped mem_req is an abort; no error.
- WAIT, wait_cnt==MAX_WAIT & !mem_ready: →IDLE, mem_timeout←1. mem_timeout clears only on rst.
- branch_flush = B_taken & !mem_stall.
- hazard = raw & !B_taken & !mem_stall. The branch wins because the ID instruction is wrong-path.
- pc_freeze = if_id_freeze = mem_stall | hazard.
- if_id_flush = branch_flush.
- id_ex_flush = branch_flush | hazard.
- id_ex_freeze = back_freeze = mem_stall.
- stall_cycles +1 every cycle pc_freeze=1. flush_events +1 every cycle branch_flush=1. Both saturate at all-ones.

## Timing
- All freeze/flush outputs are combinational from the current inputs and registered state. They take effect at the next edge.
- FSM, wait_cnt, mem_timeout and counters update on the rising clk edge.
- rst forces the state to IDLE. It also clears wait_cnt, the counters and mem_timeout.
- While rst=1, all freeze/flush outputs are forced to 0, including mid-wait.
- A single request with mem_ready low for N<MAX_WAIT cycles gives exactly N stall cycles.
- A request whose mem_ready never rises gives exactly MAX_WAIT stall cycles. The request is then released and mem_timeout rises one edge later.
- A branch during a memory stall is deferred. It flushes on the first cycle mem_stall=0, while B_taken is still held in the frozen ID/EX.
- A hazard persisting N cycles gives N bubbles. Each cycle counts in stall_cycles.

## Structure
- Shared package arm_pipe_pkg: FSM state enum (IDLE, WAIT), register-index width constant (4), default CNT_W.
- Sub-module sat_counter, parameterised by width with enable input, instantiated twice for stall_cycles and flush_events.
- The hazard compare is inline combinational logic.

## Test plan
- Reset: rst=1 for 2 cycles with mem_req=1 and B_taken=1 → all outputs 0, counters 0, mem_timeout 0.
- Stall without forwarding: fwd_en=0, src1=3, hasSrc1=1, EXE_Dest=3, EXE_WB_EN=1 → pc_freeze=if_id_freeze=id_ex_flush=1 the same cycle.
  - Repeat with MEM_Dest=3, MEM_WB_EN=1 → stall.
  - hasSrc1=0 → no stall.
- Forwarding on: fwd_en=1, src2=5, hasSrc2=1, EXE_Dest=5, EXE_WB_EN=1.
  - EXE_MEM_R_EN=0 → no stall.
  - EXE_MEM_R_EN=1 → one-cycle stall; stall_cycles=1.
- Branch with RAW: B_taken=1 and a RAW hazard → if_id_flush=id_ex_flush=1, pc_freeze=0; flush_events increments by 1.
- Memory wait with branch: mem_req=1, mem_ready low 4 cycles then high, B_taken=1 throughout.
  - back_freeze high exactly 4 cycles; flush outputs 0 during the wait.
  - if_id_flush=1 on cycle 5; mem_timeout stays 0.
- Timeout: MAX_WAIT=15, mem_req=1, mem_ready=0 forever → back_freeze high 15 cycles then low; mem_timeout=1 and sticky until rst.
